sr_prog_ctrl: RTL and testbench
===============================

Name: sr_prog_ctrl

Overview:
Bus-slave sequencer for the bit-serial configuration shift chain. Software pushes 32-bit words over the valid/ready bus. The block serialises them LSB-first into the chain for exactly CHAIN_WIDTH bits, captures the chain's outgoing bits as readback words, and finishes with a one-cycle latch strobe. It sits between the user-area bus and the chain's Sin/Sout/shift-enable pins.

Parameters:
CHAIN_WIDTH, 164, total chain length in bits per programming session (must be >= 1).
CLK_DIV, 4, clk cycles per shifted bit (must be >= 1); shift strobe period.

Ports:
clk  input  1  system clock.
reset  input  1  synchronous, active-high reset.
valid  input  1  bus request.
ready  output  1  one-cycle bus acknowledge.
wstrb  input  4  write strobes; any nonzero value = write, zero = read.
addr  input  4  register select, uses addr[3:2].
wdata  input  32  write data.
rdata  output  32  read data, valid while ready=1.
sr_sin  output  1  serial data to chain.
sr_sout  input  1  serial data from chain end.
sr_shift_en  output  1  chain advances one bit on a clk edge where this is 1.
sr_latch  output  1  one-cycle update strobe after last bit.

Behaviour:
- Reset: ready=0, rdata=0, sr_sin=0, sr_shift_en=0, sr_latch=0, state IDLE, hold empty, busy=done=aborted=0, readback word=0.
- Bus: on valid && !ready, access completes: ready=1 for exactly one cycle (next cycle), rdata registered. Exception: DATA write while hold full stalls (ready held 0) until hold empties. ready never stays high two cycles.
- Registers (addr[3:2]):
  0 CTRL: write bit0=START, bit1=ABORT (self-clearing). Read: 0.
  1 STATUS (RO): bit0 busy, bit1 done, bit2 hold_full, bit3 aborted, bits[31:16] bits_remaining.
  2 DATA: write pushes word into 1-entry hold (allowed in any state, incl. IDLE prefetch). Read returns last completed readback word.
  3 reserved: reads 0, writes ignored.
- FSM: IDLE -> WAIT_WORD -> SHIFT -> (WAIT_WORD | LATCH) -> IDLE.
  IDLE: START sets busy=1, clears done/aborted, bits_remaining=CHAIN_WIDTH -> WAIT_WORD. START while busy ignored.
  WAIT_WORD: when hold full, load shift reg from hold, hold empties, n=min(32, bits_remaining), clear readback accumulator, divider=0 -> SHIFT.
  SHIFT: sr_shift_en=1 on cycle where divider==CLK_DIV-1 (first strobe CLK_DIV cycles after entering SHIFT); same cycle sr_sin=shift_reg[0], accumulator[bit_idx] <= sr_sout; then shift reg >>1, bit_idx++, bits_remaining--. After n-th strobe: readback word <= accumulator (unshifted bits zero); bits_remaining==0 -> LATCH else WAIT_WORD.
  LATCH: sr_latch=1 one cycle, busy=0, done=1 -> IDLE.
- sr_sin = shift_reg[0] in SHIFT, 0 otherwise; sr_shift_en=0 outside SHIFT.
- Words beyond session: extra bits of last word (n<32) discarded. Hold content written after final load remains for next session.
- ABORT (any state, incl. same cycle as a shift strobe): abort wins, no shift that cycle, -> IDLE, hold cleared, busy=0, done=0, aborted=1, no sr_latch. Pending stalled DATA write then completes into empty hold.
- START and ABORT in same write: ABORT wins.
- Reset mid-session: immediate return to reset state, no latch.

Optional Feature:
SR_PROG_CTRL_IRQ_EN: adds output irq (1 bit), set the cycle after sr_latch, held until CTRL write with bit2=1 (IRQ_CLR) or reset; START does not clear it. Without macro: no irq port, CTRL bit2 ignored.

Test Plan:
- Reset, read all 4 registers -> STATUS=0, DATA=0, reserved=0; sr_shift_en/sr_latch/sr_sin low.
- CHAIN_WIDTH=40, CLK_DIV=1, chain model 40-bit SR: write DATA 0xA5A5A5A5, START, DATA 0x0000003C -> exactly 40 sr_shift_en pulses, then one sr_latch; chain holds 0x3C_A5A5A5A5 order (LSB first), STATUS done=1, bits_remaining=0.
- Repeat session with 0xFFFFFFFF, 0xFF -> DATA readback after session = 0x0000003C (last word, 8 bits, upper zero); first readback word 0xA5A5A5A5.
- CLK_DIV=4: strobes spaced exactly 4 cycles; second DATA write while hold full -> ready withheld until load, then single ready pulse.
- ABORT after 10 strobes -> shifting stops same cycle, no sr_latch, STATUS aborted=1 busy=0 hold_full=0.
- With SR_PROG_CTRL_IRQ_EN: irq rises cycle after sr_latch, persists across new START, clears on CTRL write 0x4.

Source files
------------

// File: rtl/sr_prog_ctrl.sv
// sr_prog_ctrl
// Bus-slave sequencer for the bit-serial configuration shift chain.
// Software pushes 32-bit words through a one-entry hold register. The block
// shifts them LSB-first into the chain until CHAIN_WIDTH bits have been sent,
// collects the bits falling out of the chain as readback words, and ends the
// session with a one-cycle latch strobe.
//
// Parameters:
//   CHAIN_WIDTH  chain length in bits per session (>= 1, < 65536)
//   CLK_DIV      clk cycles per shifted bit (>= 1)
//
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   valid / ready       bus request / one-cycle acknowledge
//   wstrb               nonzero = write, zero = read
//   addr                register select on addr[3:2]
//                       (0 CTRL, 1 STATUS, 2 DATA, 3 reserved)
//   wdata / rdata       write data / registered read data (valid with ready)
//   sr_sin, sr_sout     serial data to / from the chain
//   sr_shift_en         chain advances on a clk edge where this is 1
//   sr_latch            one-cycle update strobe after the last bit
//   irq                 only with SR_PROG_CTRL_IRQ_EN defined: set the cycle
//                       after sr_latch, cleared by a CTRL write with bit2=1
//
// Optional feature macro: SR_PROG_CTRL_IRQ_EN
module sr_prog_ctrl #(
   parameter int CHAIN_WIDTH = 164,
   parameter int CLK_DIV     = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        valid,
   output logic        ready,
   input  logic [3:0]  wstrb,
   input  logic [3:0]  addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        sr_sin,
   input  logic        sr_sout,
   output logic        sr_shift_en,
   output logic        sr_latch
`ifdef SR_PROG_CTRL_IRQ_EN
   ,
   output logic        irq
`endif
);

   localparam int              DIV_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
   localparam logic [15:0]     CHAIN_BITS = 16'(CHAIN_WIDTH);

   typedef enum logic [1:0] {
      IDLE,
      WAIT_WORD,
      SHIFT,
      LATCH
   } state_t;

   state_t            state;
   state_t            next_state;

   logic [31:0]       hold_data;
   logic              hold_full;
   logic [31:0]       shift_reg;
   logic [31:0]       acc;
   logic [31:0]       readback;
   logic [4:0]        bit_idx;
   logic [4:0]        last_idx;
   logic [DIV_W-1:0]  divider;
   logic [15:0]       bits_remaining;
   logic              busy;
   logic              done;
   logic              aborted;

   logic              access;
   logic              is_write;
   logic [1:0]        reg_sel;
   logic              accept;
   logic              ctrl_wr;
   logic              start_req;
   logic              abort_req;
   logic              data_wr;
   logic              strobe_tick;
   logic              word_end;
   logic              load_word;
   logic [31:0]       read_value;
   logic              unused_bits;

   // Bus decode. A DATA write that finds the hold register occupied is simply
   // not accepted, so ready stays low until the sequencer drains the hold.
   // Abort is decoded from the live bus so it can veto a strobe in the very
   // cycle it is accepted.
   always_comb begin
      access      = valid && !ready;
      is_write    = |wstrb;
      reg_sel     = addr[3:2];
      accept      = access && !(is_write && (reg_sel == 2'd2) && hold_full);
      ctrl_wr     = accept && is_write && (reg_sel == 2'd0);
      start_req   = ctrl_wr && wdata[0];
      abort_req   = ctrl_wr && wdata[1];
      data_wr     = accept && is_write && (reg_sel == 2'd2);
      strobe_tick = (state == SHIFT) && (divider == DIV_LAST) && !abort_req;
      word_end    = strobe_tick && (bit_idx == last_idx);
      load_word   = (state == WAIT_WORD) && hold_full && !abort_req;
   end

   // Register read mux; writes and the write-only/reserved slots return zero.
   always_comb begin
      read_value = 32'd0;
      if (!is_write) begin
         case (reg_sel)
            2'd1:    read_value = {bits_remaining, 12'd0, aborted, hold_full, done, busy};
            2'd2:    read_value = readback;
            default: read_value = 32'd0;
         endcase
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state and chain pin decode. Abort overrides everything, including a
   // latch that would otherwise fire this cycle.
   always_comb begin
      next_state  = state;
      sr_shift_en = strobe_tick;
      sr_sin      = (state == SHIFT) ? shift_reg[0] : 1'b0;
      sr_latch    = (state == LATCH) && !abort_req;
      if (abort_req) begin
         next_state = IDLE;
      end else begin
         case (state)
            IDLE:      if (start_req) next_state = WAIT_WORD;
            WAIT_WORD: if (hold_full) next_state = SHIFT;
            SHIFT: begin
               if (word_end) begin
                  next_state = (bits_remaining == 16'd1) ? LATCH : WAIT_WORD;
               end
            end
            LATCH:     next_state = IDLE;
            default:   next_state = IDLE;
         endcase
      end
   end

   // Datapath: bus response, hold register, shift/readback registers and the
   // status flags. The readback word is built from the accumulator plus the
   // bit arriving on the final strobe, since that bit is not yet in acc.
   always_ff @(posedge clk) begin
      if (reset) begin
         ready          <= 1'b0;
         rdata          <= 32'd0;
         hold_data      <= 32'd0;
         hold_full      <= 1'b0;
         shift_reg      <= 32'd0;
         acc            <= 32'd0;
         readback       <= 32'd0;
         bit_idx        <= 5'd0;
         last_idx       <= 5'd0;
         divider        <= '0;
         bits_remaining <= 16'd0;
         busy           <= 1'b0;
         done           <= 1'b0;
         aborted        <= 1'b0;
      end else begin
         ready <= accept;
         rdata <= accept ? read_value : 32'd0;

         if (data_wr) begin
            hold_data <= wdata;
            hold_full <= 1'b1;
         end

         if (load_word) begin
            shift_reg <= hold_data;
            hold_full <= 1'b0;
            acc       <= 32'd0;
            bit_idx   <= 5'd0;
            divider   <= '0;
            last_idx  <= (bits_remaining >= 16'd32) ? 5'd31 : 5'(bits_remaining - 16'd1);
         end

         if ((state == SHIFT) && !abort_req) begin
            if (strobe_tick) begin
               divider        <= '0;
               shift_reg      <= {1'b0, shift_reg[31:1]};
               acc[bit_idx]   <= sr_sout;
               bit_idx        <= bit_idx + 5'd1;
               bits_remaining <= bits_remaining - 16'd1;
               if (word_end) begin
                  readback <= acc | (32'(sr_sout) << bit_idx);
               end
            end else begin
               divider <= divider + DIV_W'(1);
            end
         end

         if (start_req && !abort_req && (state == IDLE)) begin
            busy           <= 1'b1;
            done           <= 1'b0;
            aborted        <= 1'b0;
            bits_remaining <= CHAIN_BITS;
         end

         if (sr_latch) begin
            busy <= 1'b0;
            done <= 1'b1;
         end

         if (abort_req) begin
            hold_full <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            aborted   <= 1'b1;
         end
      end
   end

`ifdef SR_PROG_CTRL_IRQ_EN
   // Sticky completion interrupt; a new START leaves it alone so software must
   // acknowledge it explicitly. A latch in the same cycle as the clear wins.
   always_ff @(posedge clk) begin
      if (reset) begin
         irq <= 1'b0;
      end else begin
         if (ctrl_wr && wdata[2]) irq <= 1'b0;
         if (sr_latch) irq <= 1'b1;
      end
   end

   assign unused_bits = ^{addr[1:0], wdata[31:3]};
`else
   assign unused_bits = ^{addr[1:0], wdata[31:2]};
`endif

endmodule

// File: tb/tb_sr_prog_ctrl.sv
// tb_sr_prog_ctrl
// Drives two sr_prog_ctrl instances, each with a 40-bit chain model:
//   dut_a: CLK_DIV=1 (data path, readback, abort on a strobe cycle, irq)
//   dut_b: CLK_DIV=4 (strobe spacing, DATA stall, abort mid-word, reset)
// Bus responses are checked by a scoreboard: every access pushes its expected
// read data, and a monitor pops and compares whenever ready is seen.
module tb_sr_prog_ctrl;

   localparam int CW    = 40;
   localparam int BOUND = 2000;

   localparam logic [3:0] A_CTRL   = 4'h0;
   localparam logic [3:0] A_STATUS = 4'h4;
   localparam logic [3:0] A_DATA   = 4'h8;
   localparam logic [3:0] A_RSVD   = 4'hC;

   typedef struct {
      logic [31:0] exp;
      bit          chk;
      string       tag;
   } sb_t;

   logic clk = 1'b0;
   logic reset;

   logic        a_valid, a_ready, a_sin, a_sout, a_shift_en, a_latch;
   logic [3:0]  a_wstrb, a_addr;
   logic [31:0] a_wdata, a_rdata;
   logic        b_valid, b_ready, b_sin, b_sout, b_shift_en, b_latch;
   logic [3:0]  b_wstrb, b_addr;
   logic [31:0] b_wdata, b_rdata;
`ifdef SR_PROG_CTRL_IRQ_EN
   logic        a_irq, b_irq;
`endif

   logic [CW-1:0] a_chain = '0;
   logic [CW-1:0] b_chain = '0;
   int a_stb = 0, a_lat = 0, b_stb = 0, b_lat = 0;
   int cyc = 0;
   int total = 0;
   int bad = 0;

   sb_t q_a[$];
   sb_t q_b[$];

   always #5 clk = ~clk;

   sr_prog_ctrl #(.CHAIN_WIDTH(CW), .CLK_DIV(1)) dut_a (
      .clk(clk), .reset(reset), .valid(a_valid), .ready(a_ready),
      .wstrb(a_wstrb), .addr(a_addr), .wdata(a_wdata), .rdata(a_rdata),
      .sr_sin(a_sin), .sr_sout(a_sout), .sr_shift_en(a_shift_en),
      .sr_latch(a_latch)
`ifdef SR_PROG_CTRL_IRQ_EN
      , .irq(a_irq)
`endif
   );

   sr_prog_ctrl #(.CHAIN_WIDTH(CW), .CLK_DIV(4)) dut_b (
      .clk(clk), .reset(reset), .valid(b_valid), .ready(b_ready),
      .wstrb(b_wstrb), .addr(b_addr), .wdata(b_wdata), .rdata(b_rdata),
      .sr_sin(b_sin), .sr_sout(b_sout), .sr_shift_en(b_shift_en),
      .sr_latch(b_latch)
`ifdef SR_PROG_CTRL_IRQ_EN
      , .irq(b_irq)
`endif
   );

   // Chain models: bits enter at the top and leave from bit 0, so after
   // CW shifts the first bit sent sits at bit 0.
   assign a_sout = a_chain[0];
   assign b_sout = b_chain[0];

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (a_shift_en) begin
         a_chain <= {a_sin, a_chain[CW-1:1]};
         a_stb   <= a_stb + 1;
      end
      if (b_shift_en) begin
         b_chain <= {b_sin, b_chain[CW-1:1]};
         b_stb   <= b_stb + 1;
      end
      if (a_latch) a_lat <= a_lat + 1;
      if (b_latch) b_lat <= b_lat + 1;
   end

   task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", tag, act, exp);
      end
   endtask

   // One bus access. With now=1 the request is driven immediately instead of
   // at the next falling edge.
   task automatic applyStimulus(input int sel, input bit wr_en, input logic [3:0] a,
                                input logic [31:0] d, input logic [31:0] exp,
                                input string tag, input bit now, output int wait_cyc);
      sb_t e;
      bit got;
      e.exp = exp;
      e.chk = !wr_en;
      e.tag = tag;
      if (sel == 0) q_a.push_back(e);
      else          q_b.push_back(e);
      if (!now) @(negedge clk);
      if (sel == 0) begin
         a_valid = 1'b1; a_wstrb = wr_en ? 4'hF : 4'h0; a_addr = a; a_wdata = d;
      end else begin
         b_valid = 1'b1; b_wstrb = wr_en ? 4'hF : 4'h0; b_addr = a; b_wdata = d;
      end
      wait_cyc = 0;
      got = 1'b0;
      while (!got && wait_cyc < BOUND) begin
         @(posedge clk);
         #1;
         wait_cyc++;
         got = (sel == 0) ? a_ready : b_ready;
      end
      if (sel == 0) a_valid = 1'b0;
      else          b_valid = 1'b0;
      checkOutput({tag, "_handshake"}, 64'(got), 64'd1);
   endtask

   task automatic wr(input int sel, input logic [3:0] a, input logic [31:0] d, input string tag);
      int w;
      applyStimulus(sel, 1'b1, a, d, 32'd0, tag, 1'b0, w);
   endtask

   task automatic rd(input int sel, input logic [3:0] a, input logic [31:0] exp, input string tag);
      int w;
      applyStimulus(sel, 1'b0, a, 32'd0, exp, tag, 1'b0, w);
   endtask

   task automatic waitStrobes(input int sel, input int target, input string tag);
      int n = 0;
      while (((sel == 0) ? a_stb : b_stb) < target && n < BOUND) begin
         @(negedge clk);
         n++;
      end
      checkOutput(tag, 64'(((sel == 0) ? a_stb : b_stb) >= target), 64'd1);
   endtask

   task automatic waitLatch(input int sel, input int target, input string tag);
      int n = 0;
      while (((sel == 0) ? a_lat : b_lat) < target && n < BOUND) begin
         @(negedge clk);
         n++;
      end
      checkOutput(tag, 64'(((sel == 0) ? a_lat : b_lat) >= target), 64'd1);
   endtask

   // Scoreboard monitor: pops one expectation per ready pulse and also checks
   // that ready never stays high for two cycles.
   initial begin : sb_mon
      bit pa;
      bit pb;
      sb_t e;
      pa = 1'b0;
      pb = 1'b0;
      forever begin
         @(negedge clk);
         if (a_ready) begin
            checkOutput("a_ready_one_cycle", 64'(pa), 64'd0);
            checkOutput("a_sb_entry", 64'(q_a.size() > 0), 64'd1);
            if (q_a.size() > 0) begin
               e = q_a.pop_front();
               if (e.chk) checkOutput(e.tag, 64'(a_rdata), 64'(e.exp));
            end
         end
         if (b_ready) begin
            checkOutput("b_ready_one_cycle", 64'(pb), 64'd0);
            checkOutput("b_sb_entry", 64'(q_b.size() > 0), 64'd1);
            if (q_b.size() > 0) begin
               e = q_b.pop_front();
               if (e.chk) checkOutput(e.tag, 64'(b_rdata), 64'(e.exp));
            end
         end
         pa = a_ready;
         pb = b_ready;
      end
   end

`ifdef SR_PROG_CTRL_IRQ_EN
   initial begin : irq_mon
      bit prev;
      prev = 1'b0;
      forever begin
         @(negedge clk);
         if (prev) checkOutput("a_irq_after_latch", 64'(a_irq), 64'd1);
         prev = a_latch;
      end
   end
`endif

   initial begin : watchdog
      #1000000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin : main
      int t_prev;
      int stall;
      a_valid = 1'b0; a_wstrb = 4'h0; a_addr = 4'h0; a_wdata = 32'd0;
      b_valid = 1'b0; b_wstrb = 4'h0; b_addr = 4'h0; b_wdata = 32'd0;
      reset = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;

      $display("[TB] reset state");
      checkOutput("a_reset_pins", {60'd0, a_ready, a_sin, a_shift_en, a_latch}, 64'd0);
      checkOutput("a_reset_rdata", 64'(a_rdata), 64'd0);
`ifdef SR_PROG_CTRL_IRQ_EN
      checkOutput("a_reset_irq", 64'(a_irq), 64'd0);
`endif
      rd(0, A_CTRL,   32'd0, "a_rd_ctrl_reset");
      rd(0, A_STATUS, 32'd0, "a_rd_status_reset");
      rd(0, A_DATA,   32'd0, "a_rd_data_reset");
      rd(0, A_RSVD,   32'd0, "a_rd_rsvd_reset");
      wr(0, A_RSVD, 32'hFFFF_FFFF, "a_wr_rsvd");
      rd(0, A_STATUS, 32'd0, "a_status_after_rsvd_wr");

      $display("[TB] session 1 on dut_a");
      wr(0, A_DATA, 32'hA5A5_A5A5, "a_s1_w0");
      rd(0, A_STATUS, 32'h0000_0004, "a_status_prefetch");
      wr(0, A_CTRL, 32'h1, "a_s1_start");
      wr(0, A_DATA, 32'h0000_003C, "a_s1_w1");
      waitLatch(0, 1, "a_s1_latch_seen");
      repeat (3) @(negedge clk);
      checkOutput("a_s1_strobes", 64'(a_stb), 64'd40);
      checkOutput("a_s1_latches", 64'(a_lat), 64'd1);
      checkOutput("a_s1_chain", 64'(a_chain), 64'h3C_A5A5_A5A5);
      rd(0, A_STATUS, 32'h0000_0002, "a_s1_status_done");
      rd(0, A_DATA,   32'h0000_0000, "a_s1_readback");

      $display("[TB] session 2 on dut_a");
      wr(0, A_DATA, 32'hFFFF_FFFF, "a_s2_w0");
      wr(0, A_CTRL, 32'h1, "a_s2_start");
`ifdef SR_PROG_CTRL_IRQ_EN
      checkOutput("a_irq_persists_start", 64'(a_irq), 64'd1);
`endif
      waitStrobes(0, 72, "a_s2_first_word");
      repeat (2) @(negedge clk);
      rd(0, A_STATUS, 32'h0008_0001, "a_s2_status_mid");
      rd(0, A_DATA,   32'hA5A5_A5A5, "a_s2_readback0");
      wr(0, A_DATA, 32'h0000_00FF, "a_s2_w1");
      waitLatch(0, 2, "a_s2_latch_seen");
      repeat (3) @(negedge clk);
      checkOutput("a_s2_strobes", 64'(a_stb), 64'd80);
      checkOutput("a_s2_chain", 64'(a_chain), 64'hFF_FFFF_FFFF);
      rd(0, A_DATA,   32'h0000_003C, "a_s2_readback1");
      rd(0, A_STATUS, 32'h0000_0002, "a_s2_status_done");
`ifdef SR_PROG_CTRL_IRQ_EN
      wr(0, A_CTRL, 32'h4, "a_irq_clr");
      checkOutput("a_irq_cleared", 64'(a_irq), 64'd0);
`endif

      $display("[TB] abort on a strobe cycle (dut_a)");
      wr(0, A_DATA, 32'h1234_5678, "a_s3_w0");
      wr(0, A_CTRL, 32'h1, "a_s3_start");
      waitStrobes(0, 85, "a_s3_five_strobes");
      checkOutput("a_pre_abort_strobe", 64'(a_shift_en), 64'd1);
      begin
         sb_t e;
         e.exp = 32'd0; e.chk = 1'b0; e.tag = "a_abort";
         q_a.push_back(e);
         a_valid = 1'b1; a_wstrb = 4'hF; a_addr = A_CTRL; a_wdata = 32'h2;
         #1;
         checkOutput("a_abort_kills_strobe", 64'(a_shift_en), 64'd0);
         @(posedge clk);
         #1;
         checkOutput("a_abort_handshake", 64'(a_ready), 64'd1);
         a_valid = 1'b0;
      end
      repeat (20) @(negedge clk);
      checkOutput("a_abort_strobes", 64'(a_stb), 64'd85);
      checkOutput("a_abort_no_latch", 64'(a_lat), 64'd2);
      rd(0, A_STATUS, 32'h0023_0008, "a_abort_status");
      wr(0, A_DATA, 32'h0000_0099, "a_prefetch_before_abort");
      wr(0, A_CTRL, 32'h3, "a_start_and_abort");
      repeat (10) @(negedge clk);
      checkOutput("a_start_abort_no_shift", 64'(a_stb), 64'd85);
      rd(0, A_STATUS, 32'h0023_0008, "a_start_abort_status");

      $display("[TB] strobe spacing and DATA stall (dut_b)");
      wr(1, A_CTRL, 32'h1, "b_s1_start");
      rd(1, A_STATUS, 32'h0028_0001, "b_status_waiting");
      wr(1, A_DATA, 32'h1111_1111, "b_s1_w0");
      wr(1, A_DATA, 32'h0000_0022, "b_s1_w1");
      waitStrobes(1, 1, "b_first_strobe");
      t_prev = cyc;
      for (int i = 2; i <= 4; i++) begin
         waitStrobes(1, i, "b_next_strobe");
         checkOutput("b_strobe_gap", 64'(cyc - t_prev), 64'd4);
         t_prev = cyc;
      end
      applyStimulus(1, 1'b1, A_DATA, 32'h0000_0033, 32'd0, "b_s1_stalled_wr", 1'b0, stall);
      checkOutput("b_stall_ready_after_word", 64'(b_stb), 64'd32);
      checkOutput("b_stall_long", 64'(stall >= 100), 64'd1);
      waitLatch(1, 1, "b_s1_latch_seen");
      repeat (3) @(negedge clk);
      checkOutput("b_s1_strobes", 64'(b_stb), 64'd40);
      checkOutput("b_s1_chain", 64'(b_chain), 64'h22_1111_1111);
      rd(1, A_STATUS, 32'h0000_0006, "b_s1_status_hold_kept");

      $display("[TB] abort after 10 strobes (dut_b)");
      wr(1, A_CTRL, 32'h1, "b_s2_start");
      waitStrobes(1, 50, "b_s2_ten_strobes");
      wr(1, A_CTRL, 32'h2, "b_s2_abort");
      repeat (40) @(negedge clk);
      checkOutput("b_abort_strobes", 64'(b_stb), 64'd50);
      checkOutput("b_abort_no_latch", 64'(b_lat), 64'd1);
      rd(1, A_STATUS, 32'h001E_0008, "b_abort_status");

      $display("[TB] reset mid-session (dut_b)");
      wr(1, A_CTRL, 32'h1, "b_s3_start");
      wr(1, A_DATA, 32'h0000_0005, "b_s3_w0");
      waitStrobes(1, 53, "b_s3_three_strobes");
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      checkOutput("b_reset_pins", {60'd0, b_ready, b_sin, b_shift_en, b_latch}, 64'd0);
      repeat (20) @(negedge clk);
      checkOutput("b_reset_strobes", 64'(b_stb), 64'd53);
      checkOutput("b_reset_no_latch", 64'(b_lat), 64'd1);
      rd(1, A_STATUS, 32'd0, "b_status_after_reset");
      rd(0, A_DATA,   32'd0, "a_data_after_reset");

      repeat (3) @(negedge clk);
      checkOutput("a_sb_drained", 64'(q_a.size()), 64'd0);
      checkOutput("b_sb_drained", 64'(q_b.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
